uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the transmit FIFO depth in words; power of two, at least 2.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 RST  in  1  SHALL be a synchronous, active-high reset.
REQ-005 TX_tick  in  1  SHALL be a one-CLK-cycle baud strobe; each serial bit lasts one tick period.
REQ-006 transmit  in  1  SHALL be the write request that pushes TX_DATA into the FIFO.
REQ-007 TX_DATA  in  DATA_W  SHALL be the data word to enqueue.
REQ-008 par_EN  in  1  SHALL enable the parity bit.
REQ-009 par_ODD  in  1  SHALL select parity sense: 1 = odd, 0 = even.
REQ-010 stop2  in  1  SHALL select the stop-bit count: 1 = two stop bits, 0 = one.
REQ-011 TXD  out  1  SHALL be the registered serial line output; idle level is 1.
REQ-012 busy  out  1  SHALL equal (FSM not IDLE) OR (FIFO not empty).
REQ-013 full  out  1  SHALL be 1 when the FIFO holds FIFO_DEPTH words.
REQ-014 empty  out  1  SHALL be 1 when the FIFO holds 0 words.
REQ-015 count  out  $clog2(FIFO_DEPTH)+1  SHALL be the FIFO occupancy.

Function
REQ-016 A push SHALL occur on any CLK cycle with transmit=1 and full=0; when full=1 the push SHALL be dropped, including in a cycle where a pop also happens.
REQ-017 The FIFO SHALL have no read-through: a word pushed in cycle N SHALL be poppable no earlier than cycle N+1.
REQ-018 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 count SHALL change by +1 on push-only, -1 on pop-only, and 0 on push+pop.
REQ-020 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-021 The FSM SHALL change state only in cycles with TX_tick=1.
REQ-022 TXD SHALL update in the cycle after the tick that causes the transition.
REQ-023 IDLE + tick + empty=0: the FSM SHALL pop the head word and latch par_EN, par_ODD and stop2 for the frame, then go to START with TXD=0.
REQ-024 START + tick: the FSM SHALL go to DATA with TXD = bit 0.
REQ-025 DATA SHALL shift out DATA_W bits LSB first, one per tick, using a bit counter from 0 to DATA_W-1.
REQ-026 After the last data bit, the FSM SHALL go to PARITY if the latched par_EN=1, otherwise to STOP1.
REQ-027 The parity bit SHALL equal the XOR of the DATA_W data bits for even parity, and its inverse for odd parity.
REQ-028 In STOP1 and STOP2, TXD SHALL be 1.
REQ-029 STOP1 SHALL go to STOP2 if the latched stop2=1.
REQ-030 At the tick ending the final stop bit, the FSM SHALL pop and go to START when empty=0 (back-to-back frames, no idle bit), otherwise go to IDLE.
REQ-031 Changes to par_EN, par_ODD or stop2 during a frame SHALL NOT affect the frame in progress.
REQ-032 A frame SHALL NOT start without a tick; a push into an idle, empty block SHALL wait for the next tick.

Reset
REQ-033 RST=1 SHALL, on the next edge, set the state to IDLE, TXD=1, busy=0, full=0, empty=1, count=0, clear both pointers and the bit counter, and clear the latched configuration.
REQ-034 RST SHALL take priority over TX_tick and transmit.
REQ-035 A reset mid-frame SHALL abort the frame and discard all FIFO contents; TXD SHALL be 1 the cycle after reset.

Verification
REQ-036 Scenario: DATA_W=8, par_EN=1, par_ODD=0, stop2=0; push 0xA5 -> TXD per tick: 0,1,0,1,0,0,1,0,1,0,1, then idle 1, and busy falls after the stop bit.
REQ-037 Scenario: par_EN=1, par_ODD=1; send 0x07 -> parity bit 0; with par_ODD=0 -> parity bit 1.
REQ-038 Scenario: FIFO_DEPTH=4; push 5 words in consecutive cycles with no tick -> count=4, full=1, 5th word dropped; then ticks -> exactly 4 frames, back-to-back with no idle bit between them.
REQ-039 Scenario: DATA_W=7, par_EN=0, stop2=1; send 0x55 -> 7 data bits, then two stop bits of 1, 10 ticks total per frame.
REQ-040 Scenario: assert RST at tick 4 of a frame with 2 words queued -> TXD=1 the next cycle, count=0, empty=1, busy=0, and no further frames are sent.
REQ-041 Scenario: toggle par_ODD and stop2 mid-frame -> current frame unchanged; next frame uses the new settings.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a small transmit FIFO.
//
// Words written with `transmit` are queued in a FIFO. On each baud tick the
// framer sends a start bit, DATA_W data bits (LSB first), an optional parity
// bit and one or two stop bits. Parity and stop-bit settings are captured
// when a word leaves the FIFO, so changing them mid-frame only affects later
// frames. Frames are sent back-to-back, with no idle bit, while words remain.
//
// Ports:
//   CLK       clock; all state changes on its rising edge
//   RST       synchronous active-high reset (aborts frame, flushes FIFO)
//   TX_tick   one-cycle baud strobe; one serial bit per tick period
//   transmit  write request: enqueue TX_DATA unless the FIFO is full
//   TX_DATA   data word to enqueue
//   par_EN    parity bit enable
//   par_ODD   parity sense, 1 = odd, 0 = even
//   stop2     1 = two stop bits, 0 = one
//   TXD       registered serial output, idles high
//   busy      frame in progress or FIFO not empty
//   full      FIFO holds FIFO_DEPTH words
//   empty     FIFO holds no words
//   count     FIFO occupancy

module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          TX_tick,
  input  logic                          transmit,
  input  logic [DATA_W-1:0]             TX_DATA,
  input  logic                          par_EN,
  input  logic                          par_ODD,
  input  logic                          stop2,
  output logic                          TXD,
  output logic                          busy,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  // Framer state
  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              parity_reg;
  logic              par_en_reg;
  logic              stop2_reg;
  logic              txd_reg;
  logic              last_bit;

  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  // A full FIFO refuses the write even when a pop frees a slot this cycle.
  assign push       = transmit && !fifo_full;
  assign last_bit   = (bit_cnt_reg == BW'(DATA_W - 1));

  // Storage has no reset; only the pointers and count define its contents.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= TX_DATA;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Next-state logic. Pops are only issued when the registered count is
  // non-zero, so a word written this cycle cannot be popped until the next.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    if (TX_tick) begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end
        end
        START: begin
          state_next = DATA;
        end
        DATA: begin
          if (last_bit) begin
            state_next = par_en_reg ? PARITY : STOP1;
          end
        end
        PARITY: begin
          state_next = STOP1;
        end
        STOP1: begin
          if (stop2_reg) begin
            state_next = STOP2;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
        STOP2: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Datapath. parity_reg is seeded with the odd/even sense at frame start and
  // folds in each data bit as it goes out, so it holds the parity bit by the
  // time the last data bit has been sent.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      txd_reg     <= 1'b1;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      par_en_reg  <= 1'b0;
      stop2_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        shift_reg   <= fifo_mem[rd_ptr_reg];
        parity_reg  <= par_ODD;
        par_en_reg  <= par_EN;
        stop2_reg   <= stop2;
        bit_cnt_reg <= '0;
        txd_reg     <= 1'b0;
      end else if (TX_tick) begin
        case (state_reg)
          START: begin
            txd_reg     <= shift_reg[0];
            parity_reg  <= parity_reg ^ shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= '0;
          end
          DATA: begin
            if (last_bit) begin
              txd_reg <= par_en_reg ? parity_reg : 1'b1;
            end else begin
              txd_reg     <= shift_reg[0];
              parity_reg  <= parity_reg ^ shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
          end
          PARITY, STOP1, STOP2: begin
            txd_reg <= 1'b1;
          end
          default: begin
            txd_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TXD   = txd_reg;
  assign busy  = (state_reg != IDLE) || !fifo_empty;
  assign full  = fifo_full;
  assign empty = fifo_empty;
  assign count = count_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg. Two instances run in lockstep from the same
// stimulus: an 8-bit / depth-4 unit and a 7-bit / depth-8 unit. A reference
// model represents each FIFO as a queue of words and the frame in flight as
// a queue of serial bits, and every output of both units is compared against
// it each cycle. Directed scenarios add fixed expected bit sequences.

module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       transmit;
  logic [7:0] data;
  logic       par_en;
  logic       par_odd;
  logic       stop2;

  logic       txd0, busy0, full0, empty0;
  logic [2:0] count0;
  logic       txd1, busy1, full1, empty1;
  logic [3:0] count1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pending words and remaining bits of current frame.
  int m_fifo [2][$];
  bit m_frame[2][$];

  logic [10:0] a5_seq;
  logic [9:0]  s55_seq;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .FIFO_DEPTH(4)) dut0 (
    .CLK(clk), .RST(rst), .TX_tick(tick), .transmit(transmit),
    .TX_DATA(data), .par_EN(par_en), .par_ODD(par_odd), .stop2(stop2),
    .TXD(txd0), .busy(busy0), .full(full0), .empty(empty0), .count(count0)
  );

  uart_tx_cfg #(.DATA_W(7), .FIFO_DEPTH(8)) dut1 (
    .CLK(clk), .RST(rst), .TX_tick(tick), .transmit(transmit),
    .TX_DATA(data[6:0]), .par_EN(par_en), .par_ODD(par_odd), .stop2(stop2),
    .TXD(txd1), .busy(busy1), .full(full1), .empty(empty1), .count(count1)
  );

  function automatic int dw_of(int d);
    return (d == 0) ? 8 : 7;
  endfunction

  function automatic int dep_of(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial image of one frame from the word and the current settings.
  function automatic void build_frame(int d, int w);
    int ones = 0;
    m_frame[d].push_back(1'b0);
    for (int i = 0; i < dw_of(d); i++) begin
      m_frame[d].push_back(bit'((w >> i) & 1));
      ones += (w >> i) & 1;
    end
    if (par_en) begin
      m_frame[d].push_back(bit'((ones % 2) ^ (par_odd ? 1 : 0)));
    end
    m_frame[d].push_back(1'b1);
    if (stop2) begin
      m_frame[d].push_back(1'b1);
    end
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit was_full;
      if (rst) begin
        m_fifo[d].delete();
        m_frame[d].delete();
      end else begin
        was_full = (m_fifo[d].size() == dep_of(d));
        if (tick) begin
          if (m_frame[d].size() != 0) begin
            void'(m_frame[d].pop_front());
          end
          if (m_frame[d].size() == 0 && m_fifo[d].size() != 0) begin
            build_frame(d, m_fifo[d].pop_front());
          end
        end
        if (transmit && !was_full) begin
          m_fifo[d].push_back(int'(data) & ((1 << dw_of(d)) - 1));
        end
      end
    end
  endtask

  task automatic chk_dut(int d, logic t, logic b, logic f, logic e, int c);
    logic exp_txd;
    exp_txd = (m_frame[d].size() != 0) ? m_frame[d][0] : 1'b1;
    check($sformatf("d%0d_txd", d), t, exp_txd);
    check($sformatf("d%0d_busy", d), b,
          (m_frame[d].size() != 0 || m_fifo[d].size() != 0) ? 1 : 0);
    check($sformatf("d%0d_full", d), f, (m_fifo[d].size() == dep_of(d)) ? 1 : 0);
    check($sformatf("d%0d_empty", d), e, (m_fifo[d].size() == 0) ? 1 : 0);
    check($sformatf("d%0d_count", d), c, m_fifo[d].size());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_dut(0, txd0, busy0, full0, empty0, int'(count0));
    chk_dut(1, txd1, busy1, full1, empty1, int'(count1));
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic push(logic [7:0] v);
    transmit = 1'b1;
    data     = v;
    cycle();
    transmit = 1'b0;
  endtask

  // Tick with one idle cycle in between until both units are idle.
  task automatic drain();
    for (int i = 0; i < 300 && (busy0 || busy1); i++) begin
      cycle();
      do_tick();
    end
    check("drain_idle", {31'd0, busy0 | busy1}, 0);
  endtask

  task automatic parity_case(logic odd, logic exp_par);
    par_en  = 1'b1;
    par_odd = odd;
    stop2   = 1'b0;
    push(8'h07);
    for (int i = 0; i < 10; i++) begin
      do_tick();
    end
    check($sformatf("par07_odd%0d", odd), txd0, exp_par);
    drain();
  endtask

  initial begin
    rst      = 1'b1;
    tick     = 1'b0;
    transmit = 1'b0;
    data     = 8'h00;
    par_en   = 1'b0;
    par_odd  = 1'b0;
    stop2    = 1'b0;
    a5_seq   = 11'b10101001010;
    s55_seq  = 10'b1110101010;

    // Reset, with tick and transmit active to show reset priority
    cycle();
    tick     = 1'b1;
    transmit = 1'b1;
    cycle();
    tick     = 1'b0;
    transmit = 1'b0;
    check("rst_txd", txd0, 1);
    check("rst_busy", busy0, 0);
    check("rst_empty", empty0, 1);
    check("rst_count", count0, 0);
    rst = 1'b0;
    cycle();

    // 0xA5 with even parity, one stop bit
    par_en  = 1'b1;
    par_odd = 1'b0;
    stop2   = 1'b0;
    push(8'hA5);
    cycle();
    cycle();
    check("a5_wait_tick_txd", txd0, 1);
    for (int i = 0; i < 11; i++) begin
      do_tick();
      check($sformatf("a5_bit%0d", i), txd0, a5_seq[i]);
      cycle();
    end
    check("a5_busy_stop", busy0, 1);
    do_tick();
    check("a5_idle_txd", txd0, 1);
    check("a5_busy_fall", busy0, 0);
    drain();

    // Parity sense on 0x07
    parity_case(1'b1, 1'b0);
    parity_case(1'b0, 1'b1);

    // Fill past capacity without ticks, then send back-to-back
    par_en = 1'b0;
    stop2  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(8'($urandom));
    end
    check("fill_count", count0, 4);
    check("fill_full", full0, 1);
    tick = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
    end
    check("b2b_busy_40", busy0, 1);
    cycle();
    check("b2b_busy_41", busy0, 0);
    tick = 1'b0;
    drain();

    // 7-bit unit: no parity, two stop bits, 0x55
    par_en = 1'b0;
    stop2  = 1'b1;
    push(8'h55);
    for (int i = 0; i < 10; i++) begin
      do_tick();
      check($sformatf("s55_bit%0d", i), txd1, s55_seq[i]);
    end
    check("s55_busy_10", busy1, 1);
    do_tick();
    check("s55_busy_11", busy1, 0);
    drain();

    // Reset on the fourth tick of a frame with two words queued
    par_en = 1'b1;
    stop2  = 1'b0;
    push(8'h3C);
    push(8'hC3);
    push(8'h81);
    for (int i = 0; i < 3; i++) begin
      do_tick();
    end
    check("abort_queued", count0, 2);
    tick = 1'b1;
    rst  = 1'b1;
    cycle();
    tick = 1'b0;
    rst  = 1'b0;
    check("abort_txd", txd0, 1);
    check("abort_count", count0, 0);
    check("abort_empty", empty0, 1);
    check("abort_busy", busy0, 0);
    for (int i = 0; i < 20; i++) begin
      do_tick();
    end
    check("abort_no_frames", busy0, 0);

    // Settings change mid-frame apply only to the next frame
    par_en  = 1'b1;
    par_odd = 1'b0;
    stop2   = 1'b0;
    push(8'h96);
    push(8'h96);
    for (int i = 0; i < 3; i++) begin
      do_tick();
    end
    par_odd = 1'b1;
    stop2   = 1'b1;
    drain();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick     = ($urandom_range(0, 2) == 0);
      transmit = ($urandom_range(0, 3) == 0);
      data     = 8'($urandom);
      rst      = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 15) == 0) begin
        par_en  = 1'($urandom);
        par_odd = 1'($urandom);
        stop2   = 1'($urandom);
      end
      cycle();
    end
    tick     = 1'b0;
    transmit = 1'b0;
    rst      = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
